// File: rtl/operand_fwd_unit.sv
// operand_fwd_unit: decode operand read, prioritised forwarding, writer scoreboard and stall.
// Optional stall statistics counter enabled by defining FWD_STATS_EN.
module operand_fwd_unit #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int DATA_W  = 32,
  parameter int AREG_W  = 5,
  parameter int CNT_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_valid,
  input  logic [NUM_SRC-1:0]        rd_en,
  input  logic [NUM_SRC*AREG_W-1:0] rd_addr,
  input  logic [NUM_SRC*DATA_W-1:0] rf_rdata,
  input  logic                      dst_en,
  input  logic [AREG_W-1:0]         dst_addr,
  input  logic [NUM_FWD*AREG_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_ok,
  input  logic                      wb_valid,
  input  logic [AREG_W-1:0]         wb_addr,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      ready_i,
  input  logic                      flush,
  output logic                      stall,
  output logic                      issue,
  output logic                      opnd_valid,
  output logic [NUM_SRC*DATA_W-1:0] opnd_data,
  output logic                      err,
  output logic [31:0]               stall_cnt
);
  localparam int NREG = 1 << AREG_W;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  logic [CNT_W-1:0] cnt [NREG];
  logic [NUM_SRC-1:0] rdy;
  logic [NUM_SRC*DATA_W-1:0] res;
  logic [NUM_SRC*AREG_W-1:0] held;
  logic [NREG-1:0] inc, dec;
  genvar i;
  for (i = 0; i < NUM_SRC; i++) begin : g_op
    logic [AREG_W-1:0] a;
    logic [CNT_W-1:0] c;
    logic need, fv, wv;
    logic [DATA_W-1:0] hd;
    assign a = rd_addr[i*AREG_W +: AREG_W];
    assign c = cnt[a];
    assign need = rd_en[i] && a != '0;
    // descending scan so the lowest-index matching source wins
    always_comb begin
      fv = 1'b0;
      hd = '0;
      for (int j = NUM_FWD - 1; j >= 0; j--)
        if (fwd_addr[j*AREG_W +: AREG_W] == a) begin
          fv = fwd_ok[j];
          hd = fwd_data[j*DATA_W +: DATA_W];
        end
    end
    assign wv = wb_valid && wb_addr == a && c == C_ONE;
    assign rdy[i] = !need || c == '0 || (c == C_ONE && fv) || wv;
    assign res[i*DATA_W +: DATA_W] = a == '0 ? '0 :
                                     (need && c == C_ONE && fv) ? hd :
                                     (need && wv) ? wb_data : rf_rdata[i*DATA_W +: DATA_W];
  end
  assign stall = rd_valid && (!(&rdy) || (dst_en && dst_addr != '0 && cnt[dst_addr] == '1));
  assign issue = rd_valid && !stall && ready_i && !flush;
  always_comb begin
    inc = '0;
    dec = '0;
    inc[dst_addr] = issue && dst_en && dst_addr != '0;
    dec[wb_addr] = wb_valid && wb_addr != '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      err <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++)
        if (inc[r] && !dec[r]) cnt[r] <= cnt[r] + C_ONE;
        else if (dec[r] && !inc[r]) begin
          if (cnt[r] == '0) err <= 1'b1;
          else cnt[r] <= cnt[r] - C_ONE;
        end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opnd_valid <= 1'b0;
      opnd_data <= '0;
      held <= '0;
    end else begin
      if (ready_i) begin
        opnd_valid <= issue;
        opnd_data <= res;
        for (int k = 0; k < NUM_SRC; k++)
          held[k*AREG_W +: AREG_W] <= rd_en[k] ? rd_addr[k*AREG_W +: AREG_W] : '0;
      end else begin
        // EX is stalled: keep the held bundle current with retiring results
        for (int k = 0; k < NUM_SRC; k++)
          if (held[k*AREG_W +: AREG_W] != '0 && wb_valid && wb_addr == held[k*AREG_W +: AREG_W])
            opnd_data[k*DATA_W +: DATA_W] <= wb_data;
      end
      if (flush) opnd_valid <= 1'b0;
    end
  end
`ifdef FWD_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_operand_fwd_unit.sv
// tb_operand_fwd_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_operand_fwd_unit;
  localparam int NS = 2, NF = 2, DW = 32, AW = 5, CW = 2, CMAX = 3;
  logic clk = 1'b0, reset;
  logic rd_valid, dst_en, wb_valid, ready_i, flush;
  logic [NS-1:0] rd_en;
  logic [NS*AW-1:0] rd_addr;
  logic [NS*DW-1:0] rf_rdata;
  logic [AW-1:0] dst_addr, wb_addr;
  logic [NF*AW-1:0] fwd_addr;
  logic [NF*DW-1:0] fwd_data;
  logic [NF-1:0] fwd_ok;
  logic [DW-1:0] wb_data;
  logic stall, issue, opnd_valid, err;
  logic [NS*DW-1:0] opnd_data;
  logic [31:0] stall_cnt;
  int errors = 0, checks = 0;
  int m_cnt [32];
  bit m_err, m_ov, m_stall, m_issue;
  logic [DW-1:0] m_od [NS];
  logic [DW-1:0] m_res [NS];
  logic [AW-1:0] m_ha [NS];
  logic [31:0] m_sc;

  operand_fwd_unit #(.NUM_SRC(NS), .NUM_FWD(NF), .DATA_W(DW), .AREG_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_en(rd_en), .rd_addr(rd_addr),
    .rf_rdata(rf_rdata), .dst_en(dst_en), .dst_addr(dst_addr), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .fwd_ok(fwd_ok), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .ready_i(ready_i), .flush(flush), .stall(stall), .issue(issue),
    .opnd_valid(opnd_valid), .opnd_data(opnd_data), .err(err), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  function automatic void m_comb();
    bit all_rdy;
    all_rdy = 1;
    for (int i = 0; i < NS; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] rf;
      int hj;
      a = rd_addr[i*AW +: AW];
      rf = rf_rdata[i*DW +: DW];
      hj = -1;
      for (int j = 0; j < NF; j++) if (hj < 0 && fwd_addr[j*AW +: AW] == a) hj = j;
      if (a == 0) m_res[i] = 0;
      else if (!rd_en[i] || m_cnt[a] == 0) m_res[i] = rf;
      else if (m_cnt[a] == 1 && hj >= 0 && fwd_ok[hj]) m_res[i] = fwd_data[hj*DW +: DW];
      else if (m_cnt[a] == 1 && wb_valid && wb_addr == a) m_res[i] = wb_data;
      else begin
        m_res[i] = rf;
        all_rdy = 0;
      end
    end
    m_stall = rd_valid && (!all_rdy || (dst_en && dst_addr != 0 && m_cnt[dst_addr] == CMAX));
    m_issue = rd_valid && !m_stall && ready_i && !flush;
  endfunction

  function automatic void m_seq();
    int inc_r, dec_r;
    m_comb();
    inc_r = (m_issue && dst_en && dst_addr != 0) ? int'(dst_addr) : 0;
    dec_r = (wb_valid && wb_addr != 0) ? int'(wb_addr) : 0;
    if (flush) foreach (m_cnt[r]) m_cnt[r] = 0;
    else if (!(inc_r != 0 && inc_r == dec_r)) begin
      if (inc_r != 0) m_cnt[inc_r]++;
      if (dec_r != 0) begin
        if (m_cnt[dec_r] == 0) m_err = 1;
        else m_cnt[dec_r]--;
      end
    end
    if (ready_i) begin
      m_ov = m_issue;
      for (int i = 0; i < NS; i++) begin
        m_od[i] = m_res[i];
        m_ha[i] = rd_en[i] ? rd_addr[i*AW +: AW] : '0;
      end
    end else
      for (int i = 0; i < NS; i++)
        if (m_ha[i] != 0 && wb_valid && wb_addr == m_ha[i]) m_od[i] = wb_data;
    if (flush) m_ov = 0;
`ifdef FWD_STATS_EN
    if (m_stall && m_sc != 32'hFFFFFFFF) m_sc++;
`endif
  endfunction

  function automatic logic [NS*DW-1:0] m_od_vec();
    logic [NS*DW-1:0] v;
    for (int i = 0; i < NS; i++) v[i*DW +: DW] = m_od[i];
    return v;
  endfunction

  task automatic idle();
    rd_valid = 0; rd_en = '0; rd_addr = '0; rf_rdata = '0; dst_en = 0; dst_addr = '0;
    fwd_addr = '0; fwd_data = '0; fwd_ok = '0; wb_valid = 0; wb_addr = '0; wb_data = '0;
    ready_i = 1; flush = 0;
  endtask

  task automatic settle();
    #1;
    m_comb();
  endtask

  task automatic tick();
    m_seq();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_err = 0; m_ov = 0; m_sc = 0;
    for (int i = 0; i < NS; i++) begin
      m_od[i] = 0;
      m_ha[i] = 0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (opnd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", opnd_valid); end
    checks++; if (opnd_data !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", opnd_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b want=0", err); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
    rd_valid = 1; rd_en = 2'b11; rd_addr = {5'd9, 5'd1}; dst_en = 1; dst_addr = 5'd1;
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_no_stall got=%0b want=0", stall); end
    idle();
  endtask

  task automatic test_fwd();
    rd_valid = 1; dst_en = 1; dst_addr = 5'd5;
    settle();
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL fwd_issue_r5 got=%0b want=1", issue); end
    tick();
    idle();
    rd_valid = 1; rd_en = 2'b01; rd_addr[4:0] = 5'd5; rf_rdata[31:0] = 32'h0BAD;
    fwd_addr[4:0] = 5'd5; fwd_ok = 2'b01; fwd_data[31:0] = 32'h1234;
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_ok_stall got=%0b want=0", stall); end
    tick();
    checks++; if (opnd_valid !== 1'b1) begin errors++; $display("FAIL fwd_ok_valid got=%0b want=1", opnd_valid); end
    checks++; if (opnd_data[31:0] !== 32'h1234) begin errors++; $display("FAIL fwd_ok_data got=%h want=1234", opnd_data[31:0]); end
    fwd_addr[9:5] = 5'd5; fwd_data[63:32] = 32'h5555; fwd_ok = 2'b10;
    settle();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fwd_notok_stall got=%0b want=1", stall); end
    tick();
    checks++; if (opnd_valid !== 1'b0) begin errors++; $display("FAIL fwd_notok_valid got=%0b want=0", opnd_valid); end
    fwd_ok = 2'b11;
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_prio_stall got=%0b want=0", stall); end
    tick();
    checks++; if (opnd_data[31:0] !== 32'h1234) begin errors++; $display("FAIL fwd_prio_data got=%h want=1234", opnd_data[31:0]); end
    fwd_addr = '0; fwd_ok = '0; wb_valid = 1; wb_addr = 5'd5; wb_data = 32'h7777;
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wb_bypass_stall got=%0b want=0", stall); end
    tick();
    checks++; if (opnd_data[31:0] !== 32'h7777) begin errors++; $display("FAIL wb_bypass_data got=%h want=7777", opnd_data[31:0]); end
    wb_valid = 0; rf_rdata[31:0] = 32'hAAAA1111;
    tick();
    checks++; if (opnd_data[31:0] !== 32'hAAAA1111) begin errors++; $display("FAIL rf_after_wb got=%h want=aaaa1111", opnd_data[31:0]); end
    idle();
  endtask

  task automatic test_saturate();
    rd_valid = 1; dst_en = 1; dst_addr = 5'd7;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL sat_issue%0d got=%0b want=1", k, issue); end
      tick();
    end
    wb_valid = 1; wb_addr = 5'd7;
    settle();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_full_stall got=%0b want=1", stall); end
    tick();
    wb_valid = 0;
    settle();
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL sat_after_wb_issue got=%0b want=1", issue); end
    tick();
    idle();
    wb_valid = 1; wb_addr = 5'd7;
    repeat (3) tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sat_drain_err got=%0b want=0", err); end
    idle();
  endtask

  task automatic test_hold();
    rd_valid = 1; rd_en = 2'b01; dst_en = 1; dst_addr = 5'd3;
    tick();
    dst_en = 0; rd_addr[4:0] = 5'd3; fwd_addr[4:0] = 5'd3; fwd_ok = 2'b01; fwd_data[31:0] = 32'h3333;
    tick();
    checks++; if (opnd_data[31:0] !== 32'h3333) begin errors++; $display("FAIL hold_init got=%h want=3333", opnd_data[31:0]); end
    idle();
    ready_i = 0; rd_valid = 1;
    for (int k = 1; k <= 3; k++) begin
      wb_valid = (k == 2); wb_addr = 5'd3; wb_data = 32'hDEAD;
      tick();
      checks++; if (opnd_valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d got=%0b want=1", k, opnd_valid); end
      checks++; if (opnd_data[31:0] !== (k == 1 ? 32'h3333 : 32'hDEAD)) begin errors++; $display("FAIL hold_data%0d got=%h", k, opnd_data[31:0]); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL hold_err got=%0b want=0", err); end
    idle();
    tick();
    checks++; if (opnd_valid !== 1'b0) begin errors++; $display("FAIL hold_release got=%0b want=0", opnd_valid); end
  endtask

  task automatic test_flush();
    rd_valid = 1; dst_en = 1; dst_addr = 5'd2;
    tick();
    dst_addr = 5'd9;
    repeat (2) tick();
    dst_addr = 5'd4; ready_i = 0; flush = 1;
    settle();
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL flush_issue got=%0b want=0", issue); end
    tick();
    checks++; if (opnd_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b want=0", opnd_valid); end
    idle();
    rd_valid = 1; rd_en = 2'b11; rd_addr = {5'd2, 5'd9};
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_cleared got=%0b want=0", stall); end
    tick();
    idle();
    wb_valid = 1; wb_addr = 5'd9;
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL flush_err got=%0b want=1", err); end
    idle();
  endtask

  task automatic test_zero_and_stats();
    do_reset();
    rd_valid = 1; rd_en = 2'b11; rd_addr = '0; rf_rdata = {32'h11111111, 32'h22222222};
    fwd_addr = '0; fwd_ok = 2'b11; fwd_data = {32'h33333333, 32'h44444444};
    wb_valid = 1; wb_addr = 5'd0; wb_data = 32'h55555555; dst_en = 1; dst_addr = 5'd0;
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall%0d got=%0b want=0", k, stall); end
      tick();
    end
    checks++; if (opnd_data !== '0) begin errors++; $display("FAIL zero_data got=%h want=0", opnd_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err got=%0b want=0", err); end
    idle();
    rd_valid = 1; dst_en = 1; dst_addr = 5'd1;
    tick();
    dst_en = 0; rd_en = 2'b01; rd_addr[4:0] = 5'd1;
    repeat (4) tick();
    idle();
    wb_valid = 1; wb_addr = 5'd1;
    tick();
    idle();
`ifdef FWD_STATS_EN
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL stats_cnt got=%0d want=4", stall_cnt); end
`else
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stats_cnt got=%0d want=0", stall_cnt); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      rd_valid = $urandom_range(0, 3) != 0;
      rd_en = 2'($urandom);
      for (int i = 0; i < NS; i++) rd_addr[i*AW +: AW] = 5'($urandom_range(0, 3));
      rf_rdata = {$urandom, $urandom};
      dst_en = 1'($urandom);
      dst_addr = 5'($urandom_range(0, 3));
      for (int j = 0; j < NF; j++) fwd_addr[j*AW +: AW] = 5'($urandom_range(0, 3));
      fwd_data = {$urandom, $urandom};
      fwd_ok = 2'($urandom);
      r = $urandom_range(1, 3);
      wb_valid = $urandom_range(0, 1) == 1 && m_cnt[r] > 0;
      wb_addr = 5'(r);
      wb_data = $urandom;
      ready_i = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 31) == 0;
      settle();
      checks++; if (stall !== m_stall) begin errors++; $display("FAIL rnd_stall@%0d got=%0b want=%0b", n, stall, m_stall); end
      checks++; if (issue !== m_issue) begin errors++; $display("FAIL rnd_issue@%0d got=%0b want=%0b", n, issue, m_issue); end
      tick();
      checks++; if (opnd_valid !== m_ov) begin errors++; $display("FAIL rnd_valid@%0d got=%0b want=%0b", n, opnd_valid, m_ov); end
      if (m_ov) begin
        checks++; if (opnd_data !== m_od_vec()) begin errors++; $display("FAIL rnd_data@%0d got=%h want=%h", n, opnd_data, m_od_vec()); end
      end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err@%0d got=%0b want=%0b", n, err, m_err); end
      checks++; if (stall_cnt !== m_sc) begin errors++; $display("FAIL rnd_stall_cnt@%0d got=%0d want=%0d", n, stall_cnt, m_sc); end
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    #2;
    test_reset();
    test_fwd();
    test_saturate();
    test_hold();
    test_flush();
    test_zero_and_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
